// File: rtl/muldiv_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            input_valid;
  logic            input_ready;
  logic [XLEN-1:0] input_a;
  logic [XLEN-1:0] input_b;
  logic [2:0]      function_select;
  logic            output_valid;
  logic            output_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, input_valid, input_a, input_b, function_select, output_ready,
    input  input_ready, output_valid, result
  );

  modport slave (
    input  flush, input_valid, input_a, input_b, function_select, output_ready,
    output input_ready, output_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension unit: shift-add multiply and restoring divide on operand magnitudes,
// with sign fix-up at the end; STEP_BITS bits retired per CALC cycle.
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);
  localparam int N  = XLEN / STEP_BITS;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   a_q, b_q, mcand_q, result_q;
  logic [2*XLEN-1:0] acc_q, acc_n;
  logic [2:0]        fn_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;

  logic              sgn_a, sgn_b, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b, fix_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     sum, shl;

  assign bus.input_ready  = (state_q == IDLE);
  assign bus.output_valid = (state_q == DONE);
  assign bus.result       = result_q;

  assign sgn_a    = (fn_q == 3'b001) | (fn_q == 3'b010) | (fn_q == 3'b100) | (fn_q == 3'b110);
  assign sgn_b    = (fn_q == 3'b001) | (fn_q == 3'b100) | (fn_q == 3'b110);
  assign sa       = sgn_a & a_q[XLEN-1];
  assign sb       = sgn_b & b_q[XLEN-1];
  assign mag_a    = sa ? -a_q : a_q;
  assign mag_b    = sb ? -b_q : b_q;
  assign div_zero = fn_q[2] & (b_q == '0);
  assign div_ovf  = fn_q[2] & ~fn_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);

  // acc holds {hi, lo}: multiply keeps partial product in hi and multiplier in lo;
  // divide keeps partial remainder in hi and dividend bits shifting into quotient in lo.
  always_comb begin
    acc_n = acc_q;
    sum   = '0;
    shl   = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (!fn_q[2]) begin
        sum   = {1'b0, acc_n[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_n[0]}} & {1'b0, mcand_q});
        acc_n = {sum, acc_n[XLEN-1:1]};
      end else begin
        shl = {acc_n[2*XLEN-1:XLEN], acc_n[XLEN-1]};
        sum = shl - {1'b0, mcand_q};
        if (!sum[XLEN]) acc_n = {sum[XLEN-1:0], acc_n[XLEN-2:0], 1'b1};
        else            acc_n = {shl[XLEN-1:0], acc_n[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    fix_res = prod[XLEN-1:0];
    case (fn_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:                fix_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  // PREP spends two cycles: the first registers magnitudes and sign, the second dispatches,
  // keeping operand negation off the special-case compare path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      fn_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.input_valid) begin
          a_q     <= bus.input_a;
          b_q     <= bus.input_b;
          fn_q    <= bus.function_select;
          cnt_q   <= '0;
          state_q <= PREP;
        end
        PREP: if (cnt_q == '0) begin
          cnt_q <= CW'(1);
          neg_q <= (fn_q[2] & fn_q[1]) ? sa : (sa ^ sb);
          if (fn_q[2]) begin
            mcand_q <= mag_b;
            acc_q   <= {{XLEN{1'b0}}, mag_a};
          end else begin
            mcand_q <= mag_a;
            acc_q   <= {{XLEN{1'b0}}, mag_b};
          end
        end else begin
          cnt_q <= '0;
          if (div_zero) begin
            result_q <= fn_q[1] ? a_q : '1;
            state_q  <= DONE;
          end else if (div_ovf) begin
            result_q <= fn_q[1] ? '0 : a_q;
            state_q  <= DONE;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_n;
          if (cnt_q == CW'(N-1)) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          result_q <= fix_res;
          state_q  <= DONE;
        end
        DONE: if (bus.output_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, specials, backpressure, flush, async reset.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.XLEN(32)) bus ();
  muldiv_if #(.XLEN(32)) bus2 ();

  muldiv_unit #(.XLEN(32), .STEP_BITS(1)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  muldiv_unit #(.XLEN(32), .STEP_BITS(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  always #5 clk = ~clk;

  // Issue one op on bus, report edges from accept until output_valid, then the result.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] r);
    @(negedge clk);
    bus.input_valid = 1'b1; bus.function_select = f; bus.input_a = a; bus.input_b = b;
    @(posedge clk); #1;
    bus.input_valid = 1'b0; bus.input_a = 32'hDEADBEEF; bus.input_b = 32'h0BADF00D;
    bus.function_select = 3'b000;
    lat = 0;
    while (!bus.output_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    r = bus.result;
  endtask

  task automatic take_result();
    @(negedge clk); bus.output_ready = 1'b1;
    @(posedge clk); #1; bus.output_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.input_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.input_ready); end
    checks++; if (bus.output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.output_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] r;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, lat, r);
    checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_res got %h want ffffffeb", r); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL mul_lat got %0d want 35", lat); end
    take_result();
    // Same op on the two-bits-per-cycle instance.
    @(negedge clk);
    bus2.input_valid = 1'b1; bus2.function_select = 3'b000;
    bus2.input_a = 32'd7; bus2.input_b = 32'hFFFFFFFD;
    @(posedge clk); #1; bus2.input_valid = 1'b0; lat = 0;
    while (!bus2.output_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++; if (bus2.result !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul2_res got %h want ffffffeb", bus2.result); end
    checks++; if (lat !== 19) begin errors++; $display("FAIL mul2_lat got %0d want 19", lat); end
    @(negedge clk); bus2.output_ready = 1'b1;
    @(posedge clk); #1; bus2.output_ready = 1'b0;
  endtask

  task automatic test_mulh();
    logic [2:0]  fv [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
    logic [31:0] av [4] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bv [4] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] ev [4] = '{32'h40000000, 32'hC0000000, 32'h40000000, 32'hFFFFFFFF};
    int lat; logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], lat, r);
      checks++; if (r !== ev[i]) begin errors++; $display("FAIL mulh_%0d got %h want %h", i, r, ev[i]); end
      take_result();
    end
  endtask

  task automatic test_div();
    logic [2:0]  fv [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] ev [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001};
    int lat; logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], 32'hFFFFFFF9, 32'd2, lat, r);
      checks++; if (r !== ev[i]) begin errors++; $display("FAIL div_%0d got %h want %h", i, r, ev[i]); end
      if (i == 0) begin
        checks++; if (lat !== 35) begin errors++; $display("FAIL div_lat got %0d want 35", lat); end
      end
      take_result();
    end
  endtask

  task automatic test_special();
    logic [2:0]  fv [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] av [4] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] bv [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [4] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    int lat; logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], lat, r);
      checks++; if (r !== ev[i]) begin errors++; $display("FAIL special_%0d got %h want %h", i, r, ev[i]); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL special_lat_%0d got %0d want 2", i, lat); end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] r; int bad = 0;
    run_op(3'b011, 32'h00010000, 32'h00030000, lat, r);
    checks++; if (r !== 32'h00000003) begin errors++; $display("FAIL bp_res got %h want 3", r); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.output_valid !== 1'b1 || bus.result !== 32'h3 || bus.input_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    take_result();
    checks++; if (bus.input_ready !== 1'b1 || bus.output_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", bus.input_ready, bus.output_valid);
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] r; int seen = 0;
    // Flush in IDLE must block acceptance.
    @(negedge clk);
    bus.flush = 1'b1; bus.input_valid = 1'b1; bus.function_select = 3'b000;
    bus.input_a = 32'd3; bus.input_b = 32'd3;
    @(posedge clk); #1;
    checks++; if (bus.input_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got ready=%b want 1", bus.input_ready); end
    @(negedge clk); bus.flush = 1'b0; bus.input_valid = 1'b1;
    bus.function_select = 3'b101; bus.input_a = 32'd1000; bus.input_b = 32'd3;
    @(posedge clk); #1; bus.input_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.input_ready !== 1'b1 || bus.output_valid !== 1'b0) begin
      errors++; $display("FAIL flush_calc got ready=%b valid=%b want 1/0", bus.input_ready, bus.output_valid);
    end
    @(negedge clk); bus.flush = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.output_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_novalid got %0d valid cycles want 0", seen); end
    run_op(3'b100, 32'd100, 32'd7, lat, r);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL flush_next got %h want 0000000e", r); end
    take_result();
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] r;
    run_op(3'b111, 32'd100, 32'd7, lat, r);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL b2b_rem got %h want 2", r); end
    take_result();
    run_op(3'b000, 32'h12345678, 32'h10, lat, r);
    checks++; if (r !== 32'h23456780) begin errors++; $display("FAIL b2b_mul got %h want 23456780", r); end
    take_result();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.input_valid = 1'b1; bus.function_select = 3'b000; bus.input_a = 32'd5; bus.input_b = 32'd6;
    @(posedge clk); #1; bus.input_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3; reset_n = 1'b0; #1;
    checks++; if (bus.output_valid !== 1'b0 || bus.result !== 32'h0 || bus.input_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got valid=%b result=%h ready=%b want 0/0/1",
                         bus.output_valid, bus.result, bus.input_ready);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    bus.flush = 1'b0; bus.input_valid = 1'b0; bus.input_a = '0; bus.input_b = '0;
    bus.function_select = 3'b000; bus.output_ready = 1'b0;
    bus2.flush = 1'b0; bus2.input_valid = 1'b0; bus2.input_a = '0; bus2.input_b = '0;
    bus2.function_select = 3'b000; bus2.output_ready = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
